perceptron_ctrl: RTL and testbench
==================================

# perceptron_ctrl

Sequencer and weight store for the single-neuron perceptron. Accepts load, infer and train commands over a valid/ready interface. Time-multiplexes one signed adder across the N_IN inputs, thresholds the sum, and applies the perceptron learning rule on mismatch. Sits between the top-level pin wrapper (command decode from `ui_in`/`uio_in`) and the result pins.

## Interface
- `N_IN`, 8: number of binary inputs; also the number of weights.
- `W_WIDTH`, 4: signed weight/bias width, two's complement.
- `ACC_WIDTH`, 8: signed accumulator width; must be ≥ W_WIDTH + clog2(N_IN+1).

- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command; high only in IDLE.
- `cmd_op` in 2: 00 LOAD_W, 01 LOAD_B, 10 INFER, 11 TRAIN.
- `cmd_addr` in clog2(N_IN): weight index for LOAD_W.
- `cmd_data` in N_IN: the low W_WIDTH bits are the weight/bias value for LOAD_W/LOAD_B; the full vector is x for INFER/TRAIN.
- `cmd_label` in 1: target class for TRAIN.
- `res_valid` out 1: one-cycle pulse, result fields valid.
- `res_out` out 1: classification, 1 when acc ≥ 0.
- `res_acc` out ACC_WIDTH: signed sum, held until the next result.
- `res_err` out 1: TRAIN only, res_out ≠ cmd_label; 0 for INFER.
- `rd_addr` in clog2(N_IN): weight readback index.
- `rd_data` out W_WIDTH: combinational readout of w[rd_addr].
- `rd_bias` out W_WIDTH: combinational readout of the bias.

## Operation
- Handshake: a command is accepted on an edge where cmd_valid && cmd_ready. cmd_valid while cmd_ready=0 is ignored and not queued.
- LOAD_W / LOAD_B: write on the accept edge. The block stays in IDLE, so back-to-back loads run one per cycle.
- INFER / TRAIN: latch x, label and op. Go IDLE→ACCUM.
- ACCUM (N_IN cycles, i = 0..N_IN-1):
  - acc initialised to sext(bias) on accept.
  - Each cycle: acc += x[i] ? sext(w[i]) : 0.
  - Defaults cannot overflow, so no saturation on acc.
- DECIDE (1 cycle):
  - Register res_acc ← acc, res_out ← (acc ≥ 0), res_err ← (op==TRAIN && res_out≠label).
  - Pulse res_valid on the following cycle.
- After DECIDE:
  - INFER, or TRAIN without mismatch → IDLE.
  - TRAIN with mismatch → UPDATE.
- UPDATE (N_IN cycles, i = 0..N_IN-1):
  - If x[i], w[i] ← sat(w[i] + d), where d = +1 if label=1, else −1.
  - Bias ← sat(bias + d) in the first UPDATE cycle.
  - Saturation range: [−2^(W_WIDTH−1), 2^(W_WIDTH−1)−1].
- After UPDATE → IDLE.
- States: IDLE, ACCUM, DECIDE, UPDATE.
- Reset (rst_n low at an edge), from any state including mid-ACCUM/UPDATE:
  - state ← IDLE; all weights and bias ← 0.
  - acc, res_acc, res_out, res_err, res_valid ← 0.
  - cmd_ready ← 0 while rst_n is low.
  - An aborted operation produces no res_valid.

## Timing
- Accept edge = cycle 0. ACCUM occupies cycles 1..N_IN, DECIDE is cycle N_IN+1, res_valid is high in cycle N_IN+2 (10 with defaults).
- cmd_ready:
  - Returns high in cycle N_IN+2 for INFER or non-mismatch TRAIN; a new command may be accepted in the same cycle res_valid is high.
  - Returns high in cycle 2·N_IN+2 (18) for mismatch TRAIN.
- cmd_ready is high in the first cycle after rst_n deasserts.
- rd_data/rd_bias reflect a write in the cycle after the write edge.

## Structure
- Package `perceptron_pkg`:
  - op encoding enum and state enum.
  - Default N_IN/W_WIDTH/ACC_WIDTH localparams.
- Sub-module `sat_step`: combinational W_WIDTH signed ±1 with saturation. Used for the weights and the bias.
- Weights are held in a flat register array indexed by a single counter shared by ACCUM and UPDATE.

## Test plan
- Reset: hold rst_n low for 2 cycles with prior weights loaded → rd_data=0 for all addresses, rd_bias=0, res_valid=0; cmd_ready=1 in the first cycle after release.
- Infer: load w = {1,−2,3,0,0,0,0,0} (w0..w7), bias=−3; INFER x=8'b0000_0101 → res_valid exactly 10 cycles after accept, res_acc=1, res_out=1, res_err=0.
- Train mismatch: all weights and bias 0; TRAIN x=8'h0F, label=0 → res_acc=0, res_out=1, res_err=1. Afterwards w0..w3=−1, w4..w7=0, bias=−1, and cmd_ready returns 18 cycles after accept.
- Saturation: w0=−8, bias=7, other weights 0; TRAIN x=8'h01, label=1 → res_acc=−1, res_out=0, res_err=1. Afterwards w0=−7 and bias stays 7.
- Busy handling: INFER accepted, then cmd_valid held high with LOAD_W addr 0 data 5 during cycles 1..9 → w0 unchanged until cmd_ready=1, then written once.
- Reset mid-op: assert rst_n low at cycle 4 of a TRAIN → no res_valid pulse, all weights 0, state IDLE.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared encodings and default sizing for the single-neuron perceptron controller.
package perceptron_pkg;

    localparam int PCT_N_IN      = 8;
    localparam int PCT_W_WIDTH   = 4;
    localparam int PCT_ACC_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_LOAD_W = 2'b00,
        OP_LOAD_B = 2'b01,
        OP_INFER  = 2'b10,
        OP_TRAIN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DECIDE = 2'd2,
        ST_UPDATE = 2'd3
    } state_e;

endpackage

// File: rtl/sat_step.sv
// Signed +1/-1 step that clamps at the two's-complement limits instead of wrapping.
module sat_step #(
    parameter int W = 4
) (
    input  logic [W-1:0] val_i,
    input  logic         up_i,
    output logic [W-1:0] res_o
);

    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    always_comb begin
        if (up_i) begin
            res_o = (val_i == MAX_V) ? MAX_V : val_i + W'(1);
        end else begin
            res_o = (val_i == MIN_V) ? MIN_V : val_i - W'(1);
        end
    end

endmodule

// File: rtl/perceptron_ctrl.sv
// Command sequencer and weight store: bit-serial accumulate, threshold, and
// perceptron-rule weight update on a training mismatch.
module perceptron_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_IN      = PCT_N_IN,
    parameter int W_WIDTH   = PCT_W_WIDTH,
    parameter int ACC_WIDTH = PCT_ACC_WIDTH,
    localparam int IDX_W    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [IDX_W-1:0]     cmd_addr,
    input  logic [N_IN-1:0]      cmd_data,
    input  logic                 cmd_label,
    output logic                 res_valid,
    output logic                 res_out,
    output logic [ACC_WIDTH-1:0] res_acc,
    output logic                 res_err,
    input  logic [IDX_W-1:0]     rd_addr,
    output logic [W_WIDTH-1:0]   rd_data,
    output logic [W_WIDTH-1:0]   rd_bias
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ACCUM  = ST_ACCUM;
    localparam logic [1:0] S_DECIDE = ST_DECIDE;
    localparam logic [1:0] S_UPDATE = ST_UPDATE;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_IN-1:0]      x_q, x_d;
    logic                 label_q, label_d;
    logic                 train_q, train_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] res_acc_q, res_acc_d;
    logic                 res_out_q, res_out_d;
    logic                 res_err_q, res_err_d;
    logic                 res_valid_q, res_valid_d;
    logic [W_WIDTH-1:0]   bias_q, bias_d;
    logic [W_WIDTH-1:0]   w_q [N_IN];
    logic [W_WIDTH-1:0]   w_d [N_IN];

    logic                 accept;
    logic                 load_w_we;
    logic                 upd_we;
    logic                 mismatch;
    logic [W_WIDTH-1:0]   w_cur;
    logic [W_WIDTH-1:0]   w_step;
    logic [W_WIDTH-1:0]   bias_step;
    logic [ACC_WIDTH-1:0] w_sext;
    logic [ACC_WIDTH-1:0] bias_sext;

    // Ready is gated by rst_n so nothing can be accepted during reset.
    assign cmd_ready = rst_n && (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign load_w_we = accept && (cmd_op == OP_LOAD_W);
    assign upd_we    = (state_q == S_UPDATE) && x_q[idx_q];

    assign w_cur     = w_q[idx_q];
    assign w_sext    = {{(ACC_WIDTH-W_WIDTH){w_cur[W_WIDTH-1]}}, w_cur};
    assign bias_sext = {{(ACC_WIDTH-W_WIDTH){bias_q[W_WIDTH-1]}}, bias_q};
    assign mismatch  = train_q && ((~acc_q[ACC_WIDTH-1]) != label_q);

    sat_step #(.W(W_WIDTH)) u_w_step (
        .val_i (w_cur),
        .up_i  (label_q),
        .res_o (w_step)
    );

    sat_step #(.W(W_WIDTH)) u_bias_step (
        .val_i (bias_q),
        .up_i  (label_q),
        .res_o (bias_step)
    );

    // Each weight takes a host load or, during UPDATE, its own stepped value.
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_w
            assign w_d[gi] = (load_w_we && (cmd_addr == IDX_W'(gi))) ? cmd_data[W_WIDTH-1:0] :
                             (upd_we && (idx_q == IDX_W'(gi)))       ? w_step :
                                                                       w_q[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        label_d     = label_q;
        train_d     = train_q;
        acc_d       = acc_q;
        res_acc_d   = res_acc_q;
        res_out_d   = res_out_q;
        res_err_d   = res_err_q;
        res_valid_d = 1'b0;
        bias_d      = bias_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD_B) begin
                        bias_d = cmd_data[W_WIDTH-1:0];
                    end else if (cmd_op == OP_INFER || cmd_op == OP_TRAIN) begin
                        x_d     = cmd_data;
                        label_d = cmd_label;
                        train_d = (cmd_op == OP_TRAIN);
                        acc_d   = bias_sext;
                        idx_d   = '0;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (x_q[idx_q]) begin
                    acc_d = acc_q + w_sext;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_DECIDE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DECIDE: begin
                res_acc_d   = acc_q;
                res_out_d   = ~acc_q[ACC_WIDTH-1];
                res_err_d   = mismatch;
                res_valid_d = 1'b1;
                idx_d       = '0;
                state_d     = mismatch ? S_UPDATE : S_IDLE;
            end
            S_UPDATE: begin
                if (idx_q == '0) begin
                    bias_d = bias_step;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            label_q     <= 1'b0;
            train_q     <= 1'b0;
            acc_q       <= '0;
            res_acc_q   <= '0;
            res_out_q   <= 1'b0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            bias_q      <= '0;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            label_q     <= label_d;
            train_q     <= train_d;
            acc_q       <= acc_d;
            res_acc_q   <= res_acc_d;
            res_out_q   <= res_out_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            bias_q      <= bias_d;
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_out   = res_out_q;
    assign res_acc   = res_acc_q;
    assign res_err   = res_err_q;
    assign rd_data   = w_q[rd_addr];
    assign rd_bias   = bias_q;

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Directed bench for perceptron_ctrl: a vector table for inference/no-update
// training plus hand sequences for reset, update, saturation and busy cases.
module tb_perceptron_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_label = 1'b0;
    logic       res_valid;
    logic       res_out;
    logic [7:0] res_acc;
    logic       res_err;
    logic [2:0] rd_addr = 3'd0;
    logic [3:0] rd_data;
    logic [3:0] rd_bias;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] LOAD_W = 2'b00;
    localparam logic [1:0] LOAD_B = 2'b01;
    localparam logic [1:0] INFER  = 2'b10;
    localparam logic [1:0] TRAIN  = 2'b11;

    perceptron_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_label (cmd_label),
        .res_valid (res_valid),
        .res_out   (res_out),
        .res_acc   (res_acc),
        .res_err   (res_err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_bias   (rd_bias)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] x;
        logic       lbl;
        int         acc;
        int         rout;
        int         err;
        int         lat_r;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input logic [1:0] op, input int addr, input int val);
        @(negedge clk);
        check("load_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = 3'(addr);
        cmd_data  = 8'(val);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic rd_check(input string tag, input int idx, input int exp);
        rd_addr = 3'(idx);
        #1;
        check($sformatf("%s_w%0d", tag, idx), int'($signed(rd_data)), exp);
    endtask

    // Issues one INFER/TRAIN and observes cycles 1..24 after the accept edge.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] x,
                           input logic lbl, output int acc, output int rout, output int err,
                           output int lat_v, output int lat_r, output int npulse);
        @(negedge clk);
        check({tag, "_ready_in"}, int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = x;
        cmd_label = lbl;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        acc = 0; rout = -1; err = -1; lat_v = -1; lat_r = -1; npulse = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (res_valid) begin
                npulse++;
                if (lat_v < 0) begin
                    lat_v = c;
                    acc   = int'($signed(res_acc));
                    rout  = int'(res_out);
                    err   = int'(res_err);
                end
            end
            if (cmd_ready && lat_r < 0) lat_r = c;
        end
        $display("txn %s op=%0d x=%02h lbl=%0d acc=%0d out=%0d err=%0d valid@%0d ready@%0d pulses=%0d",
                 tag, op, x, lbl, acc, rout, err, lat_v, lat_r, npulse);
    endtask

    initial begin
        int a, o, e, lv, lr, np;

        // w = {1,-2,3,0,...}, bias = -3
        tbl[0] = '{INFER, 8'h05, 1'b0,  1, 1, 0, 10};
        tbl[1] = '{INFER, 8'h00, 1'b0, -3, 0, 0, 10};
        tbl[2] = '{INFER, 8'h07, 1'b0, -1, 0, 0, 10};
        tbl[3] = '{INFER, 8'h04, 1'b0,  0, 1, 0, 10};
        tbl[4] = '{INFER, 8'h02, 1'b0, -5, 0, 0, 10};
        tbl[5] = '{INFER, 8'hFF, 1'b0, -1, 0, 0, 10};
        tbl[6] = '{TRAIN, 8'h05, 1'b1,  1, 1, 0, 10};
        tbl[7] = '{TRAIN, 8'h00, 1'b0, -3, 0, 0, 10};
        tbl[8] = '{INFER, 8'h01, 1'b0, -2, 0, 0, 10};

        // Power-up reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_low", int'(cmd_ready), 0);
        check("rst_valid", int'(res_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready_after", int'(cmd_ready), 1);
        $display("txn reset released");

        // Table-driven inference / non-updating training
        load(LOAD_W, 0, 1);
        load(LOAD_W, 1, -2);
        load(LOAD_W, 2, 3);
        load(LOAD_B, 0, -3);
        for (int i = 0; i < 9; i++) begin
            run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].x, tbl[i].lbl, a, o, e, lv, lr, np);
            check($sformatf("vec%0d_acc", i), a, tbl[i].acc);
            check($sformatf("vec%0d_out", i), o, tbl[i].rout);
            check($sformatf("vec%0d_err", i), e, tbl[i].err);
            check($sformatf("vec%0d_vlat", i), lv, 10);
            check($sformatf("vec%0d_rlat", i), lr, tbl[i].lat_r);
            check($sformatf("vec%0d_pulses", i), np, 1);
        end
        @(negedge clk);
        rd_check("tbl_keep", 0, 1);
        rd_check("tbl_keep", 1, -2);
        rd_check("tbl_keep", 2, 3);
        check("tbl_keep_bias", int'($signed(rd_bias)), -3);

        // Reset with weights loaded clears store and result
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst2_ready_low", int'(cmd_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_ready", int'(cmd_ready), 1);
        check("rst2_valid", int'(res_valid), 0);
        check("rst2_acc", int'($signed(res_acc)), 0);
        check("rst2_bias", int'($signed(rd_bias)), 0);
        for (int i = 0; i < 8; i++) rd_check("rst2", i, 0);
        $display("txn reset with weights loaded");

        // Training mismatch from all-zero weights
        run_cmd("train_mis", TRAIN, 8'h0F, 1'b0, a, o, e, lv, lr, np);
        check("mis_acc", a, 0);
        check("mis_out", o, 1);
        check("mis_err", e, 1);
        check("mis_vlat", lv, 10);
        check("mis_rlat", lr, 18);
        check("mis_pulses", np, 1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) rd_check("mis", i, (i < 4) ? -1 : 0);
        check("mis_bias", int'($signed(rd_bias)), -1);

        // Saturation at the weight and bias limits
        for (int i = 0; i < 8; i++) load(LOAD_W, i, 0);
        load(LOAD_W, 0, -8);
        load(LOAD_B, 0, 7);
        run_cmd("train_sat", TRAIN, 8'h01, 1'b1, a, o, e, lv, lr, np);
        check("sat_acc", a, -1);
        check("sat_out", o, 0);
        check("sat_err", e, 1);
        check("sat_rlat", lr, 18);
        @(negedge clk);
        rd_check("sat", 0, -7);
        rd_check("sat", 1, 0);
        check("sat_bias", int'($signed(rd_bias)), 7);

        // Load held while busy must wait for ready
        load(LOAD_W, 0, 2);
        rd_addr = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = INFER;
        cmd_data  = 8'h00;
        @(posedge clk);
        #1;
        cmd_op   = LOAD_W;
        cmd_addr = 3'd0;
        cmd_data = 8'h05;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("busy_w0_c%0d", c), int'($signed(rd_data)), 2);
            check($sformatf("busy_ready_c%0d", c), int'(cmd_ready), 0);
        end
        @(negedge clk);
        check("busy_ready_c10", int'(cmd_ready), 1);
        check("busy_valid_c10", int'(res_valid), 1);
        check("busy_acc", int'($signed(res_acc)), 7);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("busy_w0_after", int'($signed(rd_data)), 5);
        check("busy_ready_after", int'(cmd_ready), 1);
        $display("txn busy load deferred");

        // Reset in cycle 4 of a TRAIN aborts it silently
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = TRAIN;
        cmd_data  = 8'hFF;
        cmd_label = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        np = 0;
        @(negedge clk);
        check("abort_ready", int'(cmd_ready), 1);
        for (int c = 0; c < 16; c++) begin
            if (res_valid) np++;
            @(negedge clk);
        end
        check("abort_pulses", np, 0);
        check("abort_ready_late", int'(cmd_ready), 1);
        check("abort_bias", int'($signed(rd_bias)), 0);
        for (int i = 0; i < 8; i++) rd_check("abort", i, 0);
        $display("txn reset mid-train");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
